fp_mult_special_pipe: RTL and testbench
=======================================

Name: fp_mult_special_pipe

Overview:
- Parametrised, pipelined special-operand resolver for the IEEE-754 floating-point multiplier.
- Classifies operands A and B when they are accepted and carries that sideband down a delay line matched to the multiplier core's latency.
- Merges the sideband with the core's raw product and delivers the final IEEE result plus exception flags over a valid/ready handshake.
- Sits between the operand input stage and the result writeback of the FPAU multiply path.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: mantissa (fraction) field width. Total word width W = 1+EXP_W+MAN_W.
- CORE_LAT, 4: cycles from operand acceptance to core_res being valid, with the core advancing only when core_en=1. Must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A.
- b  in  W  operand B.
- core_en  out  1  advance enable for the multiplier core pipeline; equals the internal advance.
- core_res  in  W  raw product from the core, aligned CORE_LAT advances after acceptance.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  W  final product.
- flag_invalid  out  1  invalid operation (NaN input or 0×Inf).
- flag_inf  out  1  result is ±Inf from an Inf operand.
- flag_zero  out  1  result is ±0 from a zero or subnormal operand.

Behaviour:
- Reset values: out_valid=0, result=0, all flags=0, all sideband valid bits=0. In-flight operations are discarded on reset, and no stale result appears after reset release.
- Advance rule: adv = !(out_valid && !out_ready). Then in_ready=adv and core_en=adv. The whole pipe stalls as one unit; no bubble collapsing.
- Acceptance: when in_valid && in_ready, classify each operand:
  - NaN: exp all-ones, man≠0.
  - Inf: exp all-ones, man=0.
  - Zero: exp=0. Subnormals are flushed to zero.
  - Normal: otherwise.
  - sign = a[W-1] XOR b[W-1].
- Sideband stage 0 stores: vld, sign, class code, and the special result word.
- Sideband delay line: CORE_LAT registers, each loaded only on adv.
- Merge priority, evaluated at the last sideband stage:
  1. Any NaN → qNaN, flag_invalid=1.
  2. Inf with zero (either order) → qNaN, flag_invalid=1.
  3. Any Inf → {sign, all-ones exp, 0}, flag_inf=1.
  4. Any zero → {sign, 0}, flag_zero=1.
  5. Otherwise → core_res, all flags 0.
- Merged value is registered into result/flags on adv. out_valid takes the last-stage vld.
- Latency: CORE_LAT+1 cycles from acceptance to out_valid with no stall. Throughput is one result per cycle.
- Stall: while out_valid && !out_ready, result, flags and all stages hold. Order is preserved and nothing is dropped or duplicated.
- Empty pipe: out_valid=0 and result holds its last value.
- Simultaneous accept at input and drain at output in the same cycle is allowed.

Optional Feature:
- Macro NAN_PROPAGATE_EN.
- Defined: a NaN input's payload propagates, A has priority over B, the quiet bit (man MSB) is forced to 1, and the NaN's own sign is kept. 0×Inf still produces the canonical qNaN.
- Undefined: every NaN result is the canonical qNaN {0, all-ones exp, 1, zeros} (0x7FC00000 for single precision).

Decomposition:
- Shared package holds:
  - class code enum: NORM, ZERO, INF, NAN.
  - sideband struct: vld, sign, class_a, class_b, spec_word.
  - canonical-qNaN and Inf constant functions of EXP_W/MAN_W.
- One sub-module, fp_classify, is combinational operand→class and is instantiated twice.

Test Plan (EXP_W=8, MAN_W=23, CORE_LAT=4):
- a=0x7F800000, b=0x00000000 → result 0x7FC00000, flag_invalid=1, out_valid exactly 5 cycles after accept.
- a=0xFF800000, b=0x40000000 → result 0xFF800000, flag_inf=1; swapped operands give the same result.
- a=0x80000000, b=0x3F800000 → 0x80000000, flag_zero=1. Subnormal a=0x00000001, b=0xBF800000 → 0x80000000.
- a=0x7F800001, b=0x3F800000 → 0x7FC00000 without the macro; 0x7FC00001 with NAN_PROPAGATE_EN.
- 8 back-to-back normal pairs, out_ready low for 3 cycles mid-stream → in_ready=core_en=0 during the stall, all 8 results equal core_res, in order, with no duplicates.
- rst_n pulled low with 3 operations in flight → out_valid=0 immediately. After release, the first out_valid corresponds only to post-reset inputs.

Source files
------------

// File: rtl/fp_mult_special_pipe_pkg.sv
// Shared types and constant builders for the FP multiplier special-operand resolver.
// Holds the operand class enum, the sideband record and the qNaN/Inf word builders.
package fp_mult_special_pipe_pkg;

    // Widest word the sideband can carry; narrower formats zero-extend into it.
    localparam int SPEC_W_MAX = 64;

    typedef logic [SPEC_W_MAX-1:0] spec_word_t;

    typedef enum logic [1:0] {
        NORM = 2'd0,
        ZERO = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    typedef struct packed {
        logic       vld;
        logic       sign;
        fp_class_e  class_a;
        fp_class_e  class_b;
        spec_word_t spec_word;
    } sideband_t;

    function automatic spec_word_t canon_qnan(input int exp_w, input int man_w);
        spec_word_t w;
        w = '0;
        for (int i = 0; i < exp_w; i++) w[man_w + i] = 1'b1;
        w[man_w - 1] = 1'b1;
        return w;
    endfunction

    function automatic spec_word_t inf_word(input logic sign, input int exp_w, input int man_w);
        spec_word_t w;
        w = '0;
        for (int i = 0; i < exp_w; i++) w[man_w + i] = 1'b1;
        w[exp_w + man_w] = sign;
        return w;
    endfunction

endpackage

// File: rtl/fp_mult_special_pipe_if.sv
// Operand/result handshake bundle between the operand stage, the multiplier core and writeback.
// The slave modport is the resolver; the master modport is the surrounding datapath.
interface fp_mult_special_pipe_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         core_en;
    logic [W-1:0] core_res;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_invalid;
    logic         flag_inf;
    logic         flag_zero;

    modport master (
        output in_valid, a, b, core_res, out_ready,
        input  in_ready, core_en, out_valid, result, flag_invalid, flag_inf, flag_zero
    );

    modport slave (
        input  in_valid, a, b, core_res, out_ready,
        output in_ready, core_en, out_valid, result, flag_invalid, flag_inf, flag_zero
    );
endinterface

// File: rtl/fp_mult_special_pipe_classify.sv
// Combinational IEEE-754 operand classifier (NaN / Inf / zero / normal).
// Subnormals report as ZERO so the multiply path flushes them.
module fp_classify
    import fp_mult_special_pipe_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W-1:0] exp_field,
    input  logic [MAN_W-1:0] man_field,
    output fp_class_e        cls
);
    always_comb begin
        if (&exp_field) begin
            cls = (|man_field) ? NAN : INF;
        end else if (exp_field == '0) begin
            cls = ZERO;
        end else begin
            cls = NORM;
        end
    end
endmodule

// File: rtl/fp_mult_special_pipe.sv
// Special-operand resolver for the pipelined FP multiplier: classifies at accept, delays to core latency, merges.
// Optional macro NAN_PROPAGATE_EN: propagate the first NaN operand's payload (quieted) instead of canonical qNaN.
module fp_mult_special_pipe
    import fp_mult_special_pipe_pkg::*;
#(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int CORE_LAT = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    fp_mult_special_pipe_if.slave  bus
);
    localparam int W = 1 + EXP_W + MAN_W;

    fp_class_e    cls_a;
    fp_class_e    cls_b;
    logic         sign;
    logic [W-1:0] spec_word;
    sideband_t    sb_d;
    sideband_t    sb_q [CORE_LAT];
    sideband_t    sb_last;
    logic         adv;

    logic [W-1:0] m_word;
    logic         m_inv;
    logic         m_inf;
    logic         m_zero;

    logic         out_valid_q;
    logic [W-1:0] result_q;
    logic         inv_q;
    logic         inf_q;
    logic         zero_q;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .exp_field (bus.a[MAN_W +: EXP_W]),
        .man_field (bus.a[MAN_W-1:0]),
        .cls       (cls_a)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .exp_field (bus.b[MAN_W +: EXP_W]),
        .man_field (bus.b[MAN_W-1:0]),
        .cls       (cls_b)
    );

    // The whole pipe, core included, moves as one unit whenever the output slot can take a word.
    assign adv         = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = adv;
    assign bus.core_en  = adv;

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        sign      = bus.a[W-1] ^ bus.b[W-1];
        spec_word = '0;
        if (cls_a == NAN || cls_b == NAN) begin
`ifdef NAN_PROPAGATE_EN
            spec_word            = (cls_a == NAN) ? bus.a : bus.b;
            spec_word[MAN_W-1]   = 1'b1;
`else
            spec_word = W'(canon_qnan(EXP_W, MAN_W));
`endif
        end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            spec_word = W'(canon_qnan(EXP_W, MAN_W));
        end else if (cls_a == INF || cls_b == INF) begin
            spec_word = W'(inf_word(sign, EXP_W, MAN_W));
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            spec_word = {sign, {(W-1){1'b0}}};
        end
    end

    always_comb begin
        sb_d           = '0;
        sb_d.vld       = bus.in_valid;
        sb_d.sign      = sign;
        sb_d.class_a   = cls_a;
        sb_d.class_b   = cls_b;
        sb_d.spec_word = SPEC_W_MAX'(spec_word);
    end

    assign sb_last = sb_q[CORE_LAT-1];

    // Any special class overrides the core; spec_word already holds the right word for the case.
    always_comb begin
        m_word = bus.core_res;
        m_inv  = 1'b0;
        m_inf  = 1'b0;
        m_zero = 1'b0;
        if (sb_last.class_a == NAN || sb_last.class_b == NAN ||
            (sb_last.class_a == INF && sb_last.class_b == ZERO) ||
            (sb_last.class_a == ZERO && sb_last.class_b == INF)) begin
            m_word = sb_last.spec_word[W-1:0];
            m_inv  = 1'b1;
        end else if (sb_last.class_a == INF || sb_last.class_b == INF) begin
            m_word = sb_last.spec_word[W-1:0];
            m_inf  = 1'b1;
        end else if (sb_last.class_a == ZERO || sb_last.class_b == ZERO) begin
            m_word = sb_last.spec_word[W-1:0];
            m_zero = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the delay line is a handful of registers, so it is cleared whole rather than just the vld bits.
            for (int i = 0; i < CORE_LAT; i++) sb_q[i] <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            inv_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            sb_q[0] <= sb_d;
            for (int i = 1; i < CORE_LAT; i++) sb_q[i] <= sb_q[i-1];
            out_valid_q <= sb_last.vld;
            if (sb_last.vld) begin
                result_q <= m_word;
                inv_q    <= m_inv;
                inf_q    <= m_inf;
                zero_q   <= m_zero;
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.result       = result_q;
    assign bus.flag_invalid = inv_q;
    assign bus.flag_inf     = inf_q;
    assign bus.flag_zero    = zero_q;
endmodule

// File: tb/tb_fp_mult_special_pipe.sv
// Directed bench for fp_mult_special_pipe: vector table, stalled stream and reset-with-traffic sequences.
// The core is modelled as a 4-deep core_en-gated pipe whose "product" is a ^ b.
module tb_fp_mult_special_pipe;
    localparam int CORE_LAT = 4;
`ifdef NAN_PROPAGATE_EN
    localparam bit PROP = 1'b1;
`else
    localparam bit PROP = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flags;  // {invalid, inf, zero}
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fp_mult_special_pipe_if #(.W(32)) bus ();

    fp_mult_special_pipe #(.EXP_W(8), .MAN_W(23), .CORE_LAT(CORE_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] core_pipe [CORE_LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CORE_LAT; i++) core_pipe[i] <= '0;
        end else if (bus.core_en) begin
            core_pipe[0] <= bus.a ^ bus.b;
            for (int i = 1; i < CORE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
        end
    end
    assign bus.core_res = core_pipe[CORE_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One isolated operation with out_ready high; returns latency in cycles after the accept edge.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] res, output logic [2:0] fl);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = bus.result;
        fl  = {bus.flag_invalid, bus.flag_inf, bus.flag_zero};
    endtask

    vec_t        vecs [15];
    int          lat;
    logic [31:0] res;
    logic [2:0]  fl;

    initial begin
        vecs[0]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100};
        vecs[1]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100};
        vecs[2]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b010};
        vecs[3]  = '{32'h40000000, 32'hFF800000, 32'hFF800000, 3'b010};
        vecs[4]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b001};
        vecs[5]  = '{32'h00000001, 32'hBF800000, 32'h80000000, 3'b001};
        vecs[6]  = '{32'h7F800001, 32'h3F800000, PROP ? 32'h7FC00001 : 32'h7FC00000, 3'b100};
        vecs[7]  = '{32'h3F800000, 32'hFFC12345, PROP ? 32'hFFC12345 : 32'h7FC00000, 3'b100};
        vecs[8]  = '{32'h7F800001, 32'hFF800002, PROP ? 32'h7FC00001 : 32'h7FC00000, 3'b100};
        vecs[9]  = '{32'h7F800001, 32'h00000000, PROP ? 32'h7FC00001 : 32'h7FC00000, 3'b100};
        vecs[10] = '{32'hFF800000, 32'h7F800000, 32'hFF800000, 3'b010};
        vecs[11] = '{32'h7F800000, 32'h00000001, 32'h7FC00000, 3'b100};
        vecs[12] = '{32'h00800000, 32'h00000000, 32'h00000000, 3'b001};
        vecs[13] = '{32'h12345678, 32'h40490FDB, 32'h527D59A3, 3'b000};
        vecs[14] = '{32'h40000000, 32'h3F800000, 32'h7F800000, 3'b000};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset result", bus.result, 32'h0);
        check("reset flags", {29'd0, bus.flag_invalid, bus.flag_inf, bus.flag_zero}, 32'd0);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_one(vecs[i].a, vecs[i].b, lat, res, fl);
            check($sformatf("vec%0d latency", i), lat, CORE_LAT + 1);
            check($sformatf("vec%0d result", i), res, vecs[i].res);
            check($sformatf("vec%0d flags", i), {29'd0, fl}, {29'd0, vecs[i].flags});
        end

        repeat (3) @(negedge clk);
        check("empty out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("empty result holds", bus.result, vecs[14].res);

        // Back-to-back stream with a 3-cycle output stall in the middle.
        begin
            int got = 0, sent = 0, cyc = 0, stall_left = 0, extra = 0;
            bit stalled_once = 1'b0;
            logic [31:0] exp_res;
            while (got < 8 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (!stalled_once && got == 2 && bus.out_valid) begin
                    stall_left   = 3;
                    stalled_once = 1'b1;
                end
                bus.out_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                bus.in_valid = (sent < 8);
                bus.a        = 32'h3F800000 + 32'(sent);
                bus.b        = 32'h40000000 + 32'(sent << 8);
                #1;
                if (!bus.out_ready) begin
                    check("stall in_ready", {31'd0, bus.in_ready}, 32'd0);
                    check("stall core_en", {31'd0, bus.core_en}, 32'd0);
                end
                if (bus.out_valid && bus.out_ready) begin
                    exp_res = (32'h3F800000 + 32'(got)) ^ (32'h40000000 + 32'(got << 8));
                    check($sformatf("stream%0d result", got), bus.result, exp_res);
                    check($sformatf("stream%0d flags", got),
                          {29'd0, bus.flag_invalid, bus.flag_inf, bus.flag_zero}, 32'd0);
                    got++;
                end
                if (bus.in_valid && bus.in_ready) sent++;
            end
            check("stream count", got, 8);
            check("stream stalled", {31'd0, stalled_once}, 32'd1);
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (bus.out_valid) extra++;
            end
            check("stream no duplicates", extra, 0);
        end

        // Reset with traffic in flight.
        begin
            int spurious = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.a        = 32'h40000000 + 32'(i);
                bus.b        = 32'h3F800000;
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            repeat (2) @(negedge clk);
            check("pre-reset out_valid", {31'd0, bus.out_valid}, 32'd1);
            rst_n = 1'b0;
            #1;
            check("async reset out_valid", {31'd0, bus.out_valid}, 32'd0);
            check("async reset result", bus.result, 32'h0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (bus.out_valid) spurious++;
            end
            check("post-reset stale outputs", spurious, 0);
            run_one(32'h12345678, 32'h40490FDB, lat, res, fl);
            check("post-reset latency", lat, CORE_LAT + 1);
            check("post-reset result", res, 32'h527D59A3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
